// File: rtl/ibex_multdiv_pkg.sv
// ----------------------------------------------------------------------------
// ibex_multdiv_pkg
// Shared type for the slow multiply/divide path. md_op_e is the operator
// handed from the decoder to the issue controller and on to the unit.
// ----------------------------------------------------------------------------
package ibex_multdiv_pkg;

    typedef enum logic [1:0] {
        MULL = 2'd0,
        MULH = 2'd1,
        DIV  = 2'd2,
        REM  = 2'd3
    } md_op_e;

endpackage

// File: rtl/ibex_multdiv_issue.sv
// ----------------------------------------------------------------------------
// ibex_multdiv_issue
// Requester-side controller for the slow multiply/divide unit (ID stage).
// Takes one M-extension op from the decoder, latches its operands, drives the
// unit's enables/selects/ready for as long as it runs, owns the two 34-bit
// intermediate-value registers and hands the result to writeback.
//
// Ports
//   clk_i, rst_ni             clock, synchronous active-low reset
//   req_*                     decoder request (valid/ready, op, mode, operands,
//                             destination register, data-independent timing)
//   flush_i                   kill the in-flight operation
//   mult_en_o/div_en_o        dynamic enables to the unit
//   mult_sel_o/div_sel_o      static selects to the unit
//   operator_o, signed_mode_o,
//   op_a_o, op_b_o,
//   data_ind_timing_o         latched request fields presented to the unit
//   imd_val_d_i/we_i/q_o      intermediate-value register write/read
//   multdiv_ready_id_o        controller can take the unit's result
//   valid_i, multdiv_result_i unit result
//   wb_valid_o/wb_ready_i,
//   wb_rd_o, wb_data_o        writeback handshake and payload
//   last_latency_o            BUSY cycles of the last completed op (sat. 63)
// ----------------------------------------------------------------------------
module ibex_multdiv_issue
    import ibex_multdiv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  md_op_e           req_op_i,
    input  logic [1:0]       req_signed_mode_i,
    input  logic [31:0]      req_op_a_i,
    input  logic [31:0]      req_op_b_i,
    input  logic [4:0]       req_rd_i,
    input  logic             req_dit_i,
    input  logic             flush_i,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output md_op_e           operator_o,
    output logic [1:0]       signed_mode_o,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    output logic             data_ind_timing_o,
    input  logic [1:0][33:0] imd_val_d_i,
    input  logic [1:0]       imd_val_we_i,
    output logic [1:0][33:0] imd_val_q_o,
    output logic             multdiv_ready_id_o,
    input  logic             valid_i,
    input  logic [31:0]      multdiv_result_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic [5:0]       last_latency_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    md_op_e            r_op;
    logic [1:0]        r_signed_mode;
    logic [31:0]       r_op_a;
    logic [31:0]       r_op_b;
    logic [4:0]        r_rd;
    logic              r_dit;
    logic [31:0]       r_wb_data;
    logic [5:0]        r_lat;
    logic [5:0]        r_last_lat;
    logic [1:0][33:0]  r_imd;
    logic              w_accept;
    logic              w_active;
    logic              w_capture;

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    // Ready in RESP follows wb_ready_i so a new op can issue in the same
    // cycle the pending result retires; this is the only output that looks
    // at an input.
    assign req_ready_o = (r_state == S_IDLE) | ((r_state == S_RESP) & wb_ready_i);
    assign w_accept    = req_valid_i & req_ready_o & ~flush_i;
    assign w_active    = (r_state == S_BUSY) | (r_state == S_DRAIN);
    assign w_capture   = (r_state == S_BUSY) & valid_i & ~flush_i;

    // The unit must keep running through DRAIN so it walks back to its idle
    // state; dropping the enable early would strand it mid-operation.
    assign mult_sel_o         = w_active & ((r_op == MULL) | (r_op == MULH));
    assign div_sel_o          = w_active & ((r_op == DIV)  | (r_op == REM));
    assign mult_en_o          = mult_sel_o;
    assign div_en_o           = div_sel_o;
    assign multdiv_ready_id_o = w_active;

    assign operator_o         = r_op;
    assign signed_mode_o      = r_signed_mode;
    assign op_a_o             = r_op_a;
    assign op_b_o             = r_op_b;
    assign data_ind_timing_o  = r_dit;
    assign imd_val_q_o        = r_imd;
    assign wb_valid_o         = (r_state == S_RESP);
    assign wb_rd_o            = r_rd;
    assign wb_data_o          = r_wb_data;
    assign last_latency_o     = r_last_lat;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                // A flush racing the result discards it; a flush alone must
                // still let the unit finish, hence DRAIN.
                if (valid_i)      w_state_nxt = flush_i ? S_IDLE : S_RESP;
                else if (flush_i) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (valid_i) w_state_nxt = S_IDLE;
            end
            S_RESP: begin
                if (flush_i)         w_state_nxt = S_IDLE;
                else if (w_accept)   w_state_nxt = S_BUSY;
                else if (wb_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_op          <= MULL;
            r_signed_mode <= 2'b00;
            r_op_a        <= 32'd0;
            r_op_b        <= 32'd0;
            r_rd          <= 5'd0;
            r_dit         <= 1'b0;
            r_wb_data     <= 32'd0;
            r_lat         <= 6'd0;
            r_last_lat    <= 6'd0;
            r_imd         <= '0;
        end else begin
            if (w_accept) begin
                r_op          <= req_op_i;
                r_signed_mode <= req_signed_mode_i;
                r_op_a        <= req_op_a_i;
                r_op_b        <= req_op_b_i;
                r_rd          <= req_rd_i;
                r_dit         <= req_dit_i;
                r_lat         <= 6'd0;
            end else if (r_state == S_BUSY) begin
                r_lat <= sat_inc(r_lat);
            end
            // The reported latency includes the cycle that carries valid_i.
            if (w_capture) begin
                r_wb_data  <= multdiv_result_i;
                r_last_lat <= sat_inc(r_lat);
            end
            for (int k = 0; k < 2; k++) begin
                if (imd_val_we_i[k]) r_imd[k] <= imd_val_d_i[k];
            end
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
`timescale 1ns/1ps
module tb_ibex_multdiv_issue;
    import ibex_multdiv_pkg::*;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    md_op_e           req_op_i = MULL;
    logic [1:0]       req_signed_mode_i = 2'b00;
    logic [31:0]      req_op_a_i = 32'd0;
    logic [31:0]      req_op_b_i = 32'd0;
    logic [4:0]       req_rd_i = 5'd0;
    logic             req_dit_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             mult_en_o, div_en_o, mult_sel_o, div_sel_o;
    md_op_e           operator_o;
    logic [1:0]       signed_mode_o;
    logic [31:0]      op_a_o, op_b_o;
    logic             data_ind_timing_o;
    logic [1:0][33:0] imd_val_d_i = '0;
    logic [1:0]       imd_val_we_i = 2'b00;
    logic [1:0][33:0] imd_val_q_o;
    logic             multdiv_ready_id_o;
    logic             valid_i = 1'b0;
    logic [31:0]      multdiv_result_i = 32'd0;
    logic             wb_valid_o;
    logic             wb_ready_i = 1'b0;
    logic [4:0]       wb_rd_o;
    logic [31:0]      wb_data_o;
    logic [5:0]       last_latency_o;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [5:0]  lat;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [5:0] last_lat_exp = 6'd0;
    int         ucnt = 0;

    always #5 clk = ~clk;

    ibex_multdiv_issue dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_op_i           (req_op_i),
        .req_signed_mode_i  (req_signed_mode_i),
        .req_op_a_i         (req_op_a_i),
        .req_op_b_i         (req_op_b_i),
        .req_rd_i           (req_rd_i),
        .req_dit_i          (req_dit_i),
        .flush_i            (flush_i),
        .mult_en_o          (mult_en_o),
        .div_en_o           (div_en_o),
        .mult_sel_o         (mult_sel_o),
        .div_sel_o          (div_sel_o),
        .operator_o         (operator_o),
        .signed_mode_o      (signed_mode_o),
        .op_a_o             (op_a_o),
        .op_b_o             (op_b_o),
        .data_ind_timing_o  (data_ind_timing_o),
        .imd_val_d_i        (imd_val_d_i),
        .imd_val_we_i       (imd_val_we_i),
        .imd_val_q_o        (imd_val_q_o),
        .multdiv_ready_id_o (multdiv_ready_id_o),
        .valid_i            (valid_i),
        .multdiv_result_i   (multdiv_result_i),
        .wb_valid_o         (wb_valid_o),
        .wb_ready_i         (wb_ready_i),
        .wb_rd_o            (wb_rd_o),
        .wb_data_o          (wb_data_o),
        .last_latency_o     (last_latency_o)
    );

    // Reference arithmetic of the multdiv unit.
    function automatic logic [31:0] md_model(input md_op_e op, input logic [1:0] sm,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea, eb, p;
        ea = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        case (op)
            MULL: return p[31:0];
            MULH: return p[63:32];
            default: begin
                if (b == 32'd0) return (op == DIV) ? 32'hFFFF_FFFF : a;
                if (sm == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == DIV) ? a : 32'd0;
                    return (op == DIV) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
                end
                return (op == DIV) ? a / b : a % b;
            end
        endcase
    endfunction

    // Reference cycle count of the unit, including the valid cycle.
    function automatic int lat_model(input md_op_e op, input logic [31:0] b, input logic dit);
        if (op == MULL || op == MULH) return (!dit && op == MULL && b <= 32'd1) ? 2 : 33;
        return (!dit && b == 32'd0) ? 2 : 37;
    endfunction

    // Behavioural multdiv unit: runs while enabled, raises valid_i on the
    // cycle its latency elapses.
    always @(negedge clk) begin
        if (!rst_ni || !(mult_en_o || div_en_o)) begin
            ucnt    = 0;
            valid_i = 1'b0;
        end else begin
            ucnt             = ucnt + 1;
            valid_i          = (ucnt == lat_model(operator_o, op_b_o, data_ind_timing_o));
            multdiv_result_i = md_model(operator_o, signed_mode_o, op_a_o, op_b_o);
        end
    end

    // Issue one request (called at a negedge); pushes the expectation and
    // checks the first BUSY cycle.
    task automatic issue(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic dit);
        int n;
        exp_t e;
        logic is_mul;
        n = 0;
        while (!req_ready_o && n < 200) begin @(negedge clk); n++; end
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b want=1", req_ready_o); end
        req_valid_i = 1'b1; req_op_i = op; req_signed_mode_i = sm;
        req_op_a_i = a; req_op_b_i = b; req_rd_i = rd; req_dit_i = dit;
        e.rd = rd; e.data = md_model(op, sm, a, b); e.lat = 6'(lat_model(op, b, dit));
        sb.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b0;
        is_mul = (op == MULL) || (op == MULH);
        total++;
        if ({mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, wb_valid_o, req_ready_o}
            !== {is_mul, !is_mul, is_mul, !is_mul, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL issue_enables got=%b want=%b",
                     {mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, wb_valid_o, req_ready_o},
                     {is_mul, !is_mul, is_mul, !is_mul, 1'b1, 1'b0, 1'b0});
        end
        total++;
        if ({operator_o, signed_mode_o, op_a_o, op_b_o, data_ind_timing_o} !== {op, sm, a, b, dit}) begin
            bad++;
            $display("FAIL issue_latch got=%h want=%h",
                     {operator_o, signed_mode_o, op_a_o, op_b_o, data_ind_timing_o}, {op, sm, a, b, dit});
        end
    endtask

    // Scoreboard drain: wait for wb_valid_o, compare against the oldest
    // expectation, hold it for `hold` cycles, then retire it.
    task automatic check_resp(input int hold);
        int n;
        exp_t e;
        n = 0;
        while (!wb_valid_o && n < 200) begin @(negedge clk); n++; end
        total++;
        if (wb_valid_o !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL resp_wait wb_valid=%b pending=%0d want wb_valid=1", wb_valid_o, sb.size());
            return;
        end
        e = sb.pop_front();
        total++;
        if (wb_data_o !== e.data) begin bad++; $display("FAIL resp_data got=%h want=%h", wb_data_o, e.data); end
        total++;
        if (wb_rd_o !== e.rd) begin bad++; $display("FAIL resp_rd got=%0d want=%0d", wb_rd_o, e.rd); end
        total++;
        if (last_latency_o !== e.lat) begin bad++; $display("FAIL resp_latency got=%0d want=%0d", last_latency_o, e.lat); end
        last_lat_exp = e.lat;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if ({wb_valid_o, wb_rd_o, wb_data_o, req_ready_o} !== {1'b1, e.rd, e.data, 1'b0}) begin
                bad++;
                $display("FAIL resp_hold cycle=%0d got=%h want=%h", i,
                         {wb_valid_o, wb_rd_o, wb_data_o, req_ready_o}, {1'b1, e.rd, e.data, 1'b0});
            end
        end
        wb_ready_i = 1'b1;
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL resp_ready_passthru got=%b want=1", req_ready_o); end
        @(negedge clk);
        wb_ready_i = 1'b0;
        total++;
        if ({wb_valid_o, req_ready_o, mult_en_o, div_en_o} !== 4'b0100) begin
            bad++;
            $display("FAIL resp_retire got=%b want=0100", {wb_valid_o, req_ready_o, mult_en_o, div_en_o});
        end
    endtask

    task automatic test_reset;
        logic [185:0] got;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        got = {mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, wb_valid_o, data_ind_timing_o,
               signed_mode_o, operator_o, op_a_o, op_b_o, wb_rd_o, wb_data_o, last_latency_o, imd_val_q_o};
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", got); end
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end
    endtask

    task automatic test_imd;
        logic [1:0][33:0] want;
        imd_val_we_i = 2'b01; imd_val_d_i = {34'h2_AAAA_5555, 34'h1_2345_6789};
        want = {34'h0, 34'h1_2345_6789};
        @(negedge clk);
        total++;
        if (imd_val_q_o !== want) begin bad++; $display("FAIL imd_we0 got=%h want=%h", imd_val_q_o, want); end
        imd_val_we_i = 2'b10; imd_val_d_i = {34'h3_0F0F_F0F0, 34'h0};
        want = {34'h3_0F0F_F0F0, 34'h1_2345_6789};
        @(negedge clk);
        total++;
        if (imd_val_q_o !== want) begin bad++; $display("FAIL imd_we1 got=%h want=%h", imd_val_q_o, want); end
        imd_val_we_i = 2'b00; imd_val_d_i = {34'h1_1111_1111, 34'h2_2222_2222};
        @(negedge clk);
        total++;
        if (imd_val_q_o !== want) begin bad++; $display("FAIL imd_hold got=%h want=%h", imd_val_q_o, want); end
        imd_val_we_i = 2'b11;
        want = {34'h1_1111_1111, 34'h2_2222_2222};
        @(negedge clk);
        imd_val_we_i = 2'b00;
        total++;
        if (imd_val_q_o !== want) begin bad++; $display("FAIL imd_both got=%h want=%h", imd_val_q_o, want); end
    endtask

    task automatic test_mull;
        issue(MULL, 2'b00, 32'd7, 32'd6, 5'd3, 1'b0);
        check_resp(3);
        issue(MULL, 2'b00, 32'hDEAD_BEEF, 32'd1, 5'd12, 1'b0);
        check_resp(0);
    endtask

    task automatic test_div;
        issue(DIV, 2'b11, 32'hFFFF_FFEC, 32'd3, 5'd10, 1'b0);
        check_resp(1);
        issue(REM, 2'b11, 32'hFFFF_FFEC, 32'd3, 5'd11, 1'b0);
        check_resp(0);
        issue(MULH, 2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 5'd13, 1'b0);
        check_resp(0);
    endtask

    task automatic test_div0;
        issue(DIV, 2'b00, 32'd5, 32'd0, 5'd20, 1'b0);
        check_resp(0);
        issue(DIV, 2'b00, 32'd5, 32'd0, 5'd21, 1'b1);
        check_resp(0);
    endtask

    task automatic test_flush_busy;
        exp_t e;
        int n;
        logic seen;
        issue(MULH, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1'b0);
        e = sb.pop_back();
        repeat (4) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        total++;
        if ({mult_en_o, multdiv_ready_id_o, wb_valid_o, req_ready_o} !== 4'b1100) begin
            bad++;
            $display("FAIL flush_drain got=%b want=1100", {mult_en_o, multdiv_ready_id_o, wb_valid_o, req_ready_o});
        end
        seen = 1'b0;
        n = 0;
        while (!req_ready_o && n < 100) begin
            if (wb_valid_o) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready_o !== 1'b1 || seen || wb_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_drain_end ready=%b wb_seen=%b want ready=1 wb_seen=0", req_ready_o, seen | wb_valid_o);
        end
        total++;
        if (last_latency_o !== last_lat_exp) begin
            bad++; $display("FAIL flush_latency_kept got=%0d want=%0d", last_latency_o, last_lat_exp);
        end
        issue(MULL, 2'b00, 32'd2, 32'd3, 5'd4, 1'b0);
        check_resp(0);
    endtask

    task automatic test_flush_valid;
        exp_t e;
        issue(MULL, 2'b00, 32'd77, 32'd1, 5'd14, 1'b0);
        e = sb.pop_back();
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        total++;
        if ({wb_valid_o, req_ready_o, mult_en_o, multdiv_ready_id_o} !== 4'b0100) begin
            bad++;
            $display("FAIL flush_with_valid got=%b want=0100", {wb_valid_o, req_ready_o, mult_en_o, multdiv_ready_id_o});
        end
        total++;
        if (last_latency_o !== last_lat_exp) begin
            bad++; $display("FAIL flush_valid_latency got=%0d want=%0d", last_latency_o, last_lat_exp);
        end
    endtask

    task automatic test_flush_resp;
        exp_t e;
        int n;
        issue(MULL, 2'b00, 32'd5, 32'd0, 5'd15, 1'b0);
        e = sb.pop_back();
        n = 0;
        while (!wb_valid_o && n < 200) begin @(negedge clk); n++; end
        total++;
        if (wb_valid_o !== 1'b1 || last_latency_o !== e.lat) begin
            bad++; $display("FAIL flush_resp_reach wb_valid=%b lat=%0d want 1 %0d", wb_valid_o, last_latency_o, e.lat);
        end
        last_lat_exp = e.lat;
        flush_i = 1'b1; wb_ready_i = 1'b1;
        req_valid_i = 1'b1; req_op_i = DIV; req_op_a_i = 32'd9; req_op_b_i = 32'd2;
        @(negedge clk);
        flush_i = 1'b0; wb_ready_i = 1'b0; req_valid_i = 1'b0;
        total++;
        if ({wb_valid_o, req_ready_o, mult_en_o, div_en_o, multdiv_ready_id_o} !== 5'b01000) begin
            bad++;
            $display("FAIL flush_resp got=%b want=01000", {wb_valid_o, req_ready_o, mult_en_o, div_en_o, multdiv_ready_id_o});
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int n;
        issue(MULL, 2'b00, 32'd9, 32'd1, 5'd5, 1'b0);
        n = 0;
        while (!wb_valid_o && n < 200) begin @(negedge clk); n++; end
        e = sb.pop_front();
        total++;
        if ({wb_valid_o, wb_rd_o, wb_data_o, last_latency_o} !== {1'b1, e.rd, e.data, e.lat}) begin
            bad++;
            $display("FAIL b2b_first got=%h want=%h", {wb_valid_o, wb_rd_o, wb_data_o, last_latency_o},
                     {1'b1, e.rd, e.data, e.lat});
        end
        last_lat_exp = e.lat;
        wb_ready_i = 1'b1;
        req_valid_i = 1'b1; req_op_i = MULL; req_signed_mode_i = 2'b00;
        req_op_a_i = 32'd3; req_op_b_i = 32'd4; req_rd_i = 5'd7; req_dit_i = 1'b0;
        e.rd = 5'd7; e.data = md_model(MULL, 2'b00, 32'd3, 32'd4); e.lat = 6'(lat_model(MULL, 32'd4, 1'b0));
        sb.push_back(e);
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", req_ready_o); end
        @(negedge clk);
        wb_ready_i = 1'b0; req_valid_i = 1'b0;
        total++;
        if ({mult_en_o, wb_valid_o, op_a_o, op_b_o, wb_rd_o} !== {1'b1, 1'b0, 32'd3, 32'd4, 5'd7}) begin
            bad++;
            $display("FAIL b2b_no_bubble got=%h want=%h", {mult_en_o, wb_valid_o, op_a_o, op_b_o, wb_rd_o},
                     {1'b1, 1'b0, 32'd3, 32'd4, 5'd7});
        end
        check_resp(0);
    endtask

    task automatic test_rst_mid;
        exp_t e;
        logic [185:0] got;
        issue(DIV, 2'b11, 32'hFFFF_FFEC, 32'd3, 5'd17, 1'b0);
        e = sb.pop_back();
        imd_val_we_i = 2'b11; imd_val_d_i = {34'h3_FFFF_0001, 34'h2_0000_FFFF};
        @(negedge clk);
        imd_val_we_i = 2'b00;
        total++;
        if (imd_val_q_o !== {34'h3_FFFF_0001, 34'h2_0000_FFFF} || div_en_o !== 1'b1) begin
            bad++; $display("FAIL imd_busy_write got=%h div_en=%b", imd_val_q_o, div_en_o);
        end
        repeat (3) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        got = {mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, wb_valid_o, data_ind_timing_o,
               signed_mode_o, operator_o, op_a_o, op_b_o, wb_rd_o, wb_data_o, last_latency_o, imd_val_q_o};
        total++;
        if (got !== '0) begin bad++; $display("FAIL rst_mid_outputs got=%h want=0", got); end
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", req_ready_o); end
        last_lat_exp = 6'd0;
        issue(MULL, 2'b00, 32'd11, 32'd13, 5'd1, 1'b0);
        check_resp(0);
    endtask

    initial begin
        test_reset();
        test_imd();
        test_mull();
        test_div();
        test_div0();
        test_flush_busy();
        test_flush_valid();
        test_flush_resp();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
